sr_cmd_sequencer: RTL and testbench

- Upstream driver for the SR flip-flop stage.
- Accepts set/reset/toggle/delay commands over a valid/ready handshake and queues them in a small FIFO.
- Plays the commands out as clean S/R pulses of fixed width, each followed by a guard gap.
- Never drives S=R=1. Toggle direction is resolved from the flip-flop's Q fed back on q_in.

---
 rtl/sr_cmd_sequencer.sv | 164 ++++++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer: queues SET/RESET/TOGGLE/NOP commands and plays them out as S/R pulses.
// Latency: a push into an empty, idle block drives S/R from the next edge for HOLD_CYCLES cycles.
// Backpressure: req_ready drops while the FIFO holds DEPTH entries; optional stats via SR_CMD_STATS_EN.
module sr_cmd_sequencer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic [1:0]             req_op,
  output logic                   req_ready,
  input  logic                   q_in,
  output logic                   S,
  output logic                   R,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef SR_CMD_STATS_EN
  ,
  output logic [15:0]            cmd_count
`endif
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  // Counters only ever hold (cycles - 1), so CNT_MAX-1 is the largest value.
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_SET    = 2'd1;
  localparam logic [1:0] OP_RESET  = 2'd2;
  localparam logic [1:0] OP_TOGGLE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic [1:0]    head_op;

  // Ready comes from the registered count only, so a full FIFO refuses a push
  // even when a pop happens on the same edge.
  assign req_ready  = (count != (AW+1)'(DEPTH));
  assign push       = req_valid & req_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign head_op    = mem[rd_ptr];
  assign fifo_level = count;
  assign busy       = (state != IDLE) || (count != '0);

  // Command storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= req_op;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Pulse sequencer: pop in IDLE, hold the drive in DRIVE, force S=R=0 in GAP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      S     <= 1'b0;
      R     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state <= DRIVE;
            cnt   <= CW'(HOLD_CYCLES - 1);
            case (head_op)
              OP_SET: begin
                S <= 1'b1;
                R <= 1'b0;
              end
              OP_RESET: begin
                S <= 1'b0;
                R <= 1'b1;
              end
              OP_TOGGLE: begin
                // Direction is frozen from Q at the pop edge; later Q changes are ignored.
                S <= ~q_in;
                R <= q_in;
              end
              default: begin
                S <= 1'b0;
                R <= 1'b0;
              end
            endcase
          end else begin
            S <= 1'b0;
            R <= 1'b0;
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            S     <= 1'b0;
            R     <= 1'b0;
            cnt   <= CW'(GAP_CYCLES - 1);
            state <= GAP;
          end
        end
        GAP: begin
          S <= 1'b0;
          R <= 1'b0;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          S     <= 1'b0;
          R     <= 1'b0;
        end
      endcase
    end
  end

`ifdef SR_CMD_STATS_EN
  // Saturating count of real (non-NOP) commands entering DRIVE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_count <= 16'd0;
    end else if (pop && (head_op != OP_NOP) && (cmd_count != 16'hFFFF)) begin
      cmd_count <= cmd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// tb_sr_cmd_sequencer: directed and randomized checks of sr_cmd_sequencer.
// The reference model tracks a command queue plus the times at which the
// current pulse ends and the next pop becomes possible.
`timescale 1ns/1ps
module tb_sr_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int HOLD  = 2;
  localparam int GAP   = 1;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_op    = 2'd0;
  logic       q_in      = 1'b0;
  logic       req_ready;
  logic       S;
  logic       R;
  logic       busy;
  logic [2:0] fifo_level;
`ifdef SR_CMD_STATS_EN
  logic [15:0] cmd_count;
`endif

  always #5 clk = ~clk;

  sr_cmd_sequencer #(
    .DEPTH      (DEPTH),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .q_in      (q_in),
    .S         (S),
    .R         (R),
    .busy      (busy),
    .fifo_level(fifo_level)
`ifdef SR_CMD_STATS_EN
    ,
    .cmd_count (cmd_count)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  int   mq[$];
  int   cyc       = 0;
  int   next_pop  = 0;
  int   drive_end = 0;
  int   exp_cnt   = 0;
  logic ds        = 1'b0;
  logic dr        = 1'b0;
  logic exp_s, exp_r, exp_busy, exp_ready_pre, pre_ready_dut, pushed;
  int   exp_level;

  // One clock: apply inputs, advance the model across the edge, settle 1ns after it.
  task automatic step(input logic v, input logic [1:0] op, input logic q, input logic rn);
    int o;
    req_valid     = v;
    req_op        = op;
    q_in          = q;
    rst_n         = rn;
    exp_ready_pre = (mq.size() < DEPTH);
    pre_ready_dut = req_ready;
    pushed        = 1'b0;
    @(posedge clk);
    cyc++;
    if (!rn) begin
      mq.delete();
      drive_end = cyc;
      next_pop  = cyc + 1;
      ds        = 1'b0;
      dr        = 1'b0;
      exp_cnt   = 0;
    end else begin
      pushed = v && exp_ready_pre;
      if (cyc >= next_pop && mq.size() > 0) begin
        o = mq.pop_front();
        case (o)
          1:       begin ds = 1'b1; dr = 1'b0; end
          2:       begin ds = 1'b0; dr = 1'b1; end
          3:       begin ds = ~q;   dr = q;    end
          default: begin ds = 1'b0; dr = 1'b0; end
        endcase
        drive_end = cyc + HOLD;
        next_pop  = cyc + HOLD + GAP + 1;
        if (o != 0 && exp_cnt < 65535) exp_cnt++;
      end
      if (pushed) mq.push_back(int'(op));
    end
    exp_s     = (cyc < drive_end) && ds;
    exp_r     = (cyc < drive_end) && dr;
    exp_level = mq.size();
    exp_busy  = (cyc < next_pop - 1) || (mq.size() != 0);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 2'd1, 1'b0, 1'b0);
    n_total++; if (S !== 1'b0) $display("FAIL reset_S got=%b exp=0", S); else n_pass++;
    n_total++; if (R !== 1'b0) $display("FAIL reset_R got=%b exp=0", R); else n_pass++;
    n_total++; if (fifo_level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", fifo_level); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    step(1'b0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic test_single_set();
    logic es;
    step(1'b1, 2'd1, 1'b0, 1'b1);
    n_total++; if (fifo_level !== 3'd1) $display("FAIL single_level got=%0d exp=1", fifo_level); else n_pass++;
    n_total++; if (S !== 1'b0) $display("FAIL single_S0 got=%b exp=0", S); else n_pass++;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 2'd0, 1'b0, 1'b1);
      es = (i == 1 || i == 2);
      n_total++; if (S !== es) $display("FAIL single_S edge=N+%0d got=%b exp=%b", i, S, es); else n_pass++;
      n_total++; if (R !== 1'b0) $display("FAIL single_R edge=N+%0d got=%b exp=0", i, R); else n_pass++;
      if (i == 3) begin
        n_total++; if (busy !== 1'b1) $display("FAIL single_busy_gap got=%b exp=1", busy); else n_pass++;
      end
      if (i == 4) begin
        n_total++; if (busy !== 1'b0) $display("FAIL single_busy_idle got=%b exp=0", busy); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [3] = '{2'd1, 2'd2, 2'd3};
    logic lq = 1'b0;
    logic ps = 1'b0;
    logic pr = 1'b0;
    int   starts[$];
    logic kinds[$];
    for (int i = 0; i < 17; i++) begin
      if (i < 3) step(1'b1, ops[i], lq, 1'b1);
      else       step(1'b0, 2'd0, lq, 1'b1);
      n_total++; if (S !== exp_s) $display("FAIL b2b_S cyc=%0d got=%b exp=%b", cyc, S, exp_s); else n_pass++;
      n_total++; if (R !== exp_r) $display("FAIL b2b_R cyc=%0d got=%b exp=%b", cyc, R, exp_r); else n_pass++;
      if ((S && !ps) || (R && !pr)) begin
        starts.push_back(cyc);
        kinds.push_back(S);
      end
      ps = S;
      pr = R;
      if (S) lq = 1'b1;
      else if (R) lq = 1'b0;
    end
    n_total++;
    if (starts.size() != 3) begin
      $display("FAIL b2b_pulses got=%0d exp=3", starts.size());
    end else begin
      n_pass++;
      n_total++; if (kinds[0] !== 1'b1) $display("FAIL b2b_kind0 got=%b exp=1(S)", kinds[0]); else n_pass++;
      n_total++; if (kinds[1] !== 1'b0) $display("FAIL b2b_kind1 got=%b exp=0(R)", kinds[1]); else n_pass++;
      n_total++; if (kinds[2] !== 1'b1) $display("FAIL b2b_toggle got=%b exp=1(S)", kinds[2]); else n_pass++;
      n_total++; if (starts[1] - starts[0] != 4) $display("FAIL b2b_period01 got=%0d exp=4", starts[1] - starts[0]); else n_pass++;
      n_total++; if (starts[2] - starts[1] != 4) $display("FAIL b2b_period12 got=%0d exp=4", starts[2] - starts[1]); else n_pass++;
    end
  endtask

  task automatic test_full();
    int   sent  = 0;
    int   rises = 0;
    logic seen_full = 1'b0;
    logic ps = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(sent < 6, 2'd1, 1'b0, 1'b1);
      n_total++; if (pre_ready_dut !== exp_ready_pre) $display("FAIL full_ready cyc=%0d got=%b exp=%b", cyc, pre_ready_dut, exp_ready_pre); else n_pass++;
      n_total++; if (fifo_level !== exp_level) $display("FAIL full_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, exp_level); else n_pass++;
      if (pushed) sent++;
      if (exp_level == DEPTH) begin
        seen_full = 1'b1;
        n_total++; if (req_ready !== 1'b0) $display("FAIL full_ready_low cyc=%0d got=%b exp=0", cyc, req_ready); else n_pass++;
      end
      if (S && !ps) rises++;
      ps = S;
    end
    n_total++; if (!seen_full) $display("FAIL full_reached got=0 exp=1"); else n_pass++;
    n_total++; if (sent != 6) $display("FAIL full_accepted got=%0d exp=6", sent); else n_pass++;
    n_total++; if (rises != 6) $display("FAIL full_pulses got=%0d exp=6", rises); else n_pass++;
  endtask

  task automatic test_nop_reset();
    logic er;
    step(1'b1, 2'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      step(i == 1, 2'd2, 1'b0, 1'b1);
      er = (i == 5 || i == 6);
      n_total++; if (R !== er) $display("FAIL nop_R edge=N+%0d got=%b exp=%b", i, R, er); else n_pass++;
      n_total++; if (S !== 1'b0) $display("FAIL nop_S edge=N+%0d got=%b exp=0", i, S); else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    int stray = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 2'd1, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    n_total++; if (S !== 1'b1) $display("FAIL midrst_pre_S got=%b exp=1", S); else n_pass++;
    n_total++; if (fifo_level !== 3'd3) $display("FAIL midrst_pre_level got=%0d exp=3", fifo_level); else n_pass++;
    step(1'b0, 2'd0, 1'b0, 1'b0);
    n_total++; if (S !== 1'b0) $display("FAIL midrst_S got=%b exp=0", S); else n_pass++;
    n_total++; if (R !== 1'b0) $display("FAIL midrst_R got=%b exp=0", R); else n_pass++;
    n_total++; if (fifo_level !== 3'd0) $display("FAIL midrst_level got=%0d exp=0", fifo_level); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", req_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 2'd0, 1'b0, 1'b1);
      if (S !== 1'b0 || R !== 1'b0) stray++;
    end
    n_total++; if (stray != 0) $display("FAIL midrst_replay got=%0d stray cycles exp=0", stray); else n_pass++;
  endtask

`ifdef SR_CMD_STATS_EN
  task automatic test_stats();
    logic [1:0] ops [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
    step(1'b0, 2'd0, 1'b0, 1'b0);
    n_total++; if (cmd_count !== 16'd0) $display("FAIL stats_reset got=%0d exp=0", cmd_count); else n_pass++;
    for (int i = 0; i < 4; i++) step(1'b1, ops[i], 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 2'd0, 1'b0, 1'b1);
    n_total++; if (cmd_count !== 16'd3) $display("FAIL stats_count got=%0d exp=3", cmd_count); else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic v, q, rn;
    logic [1:0] op;
    step(1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 9) < 7);
      op = 2'($urandom_range(0, 3));
      q  = 1'($urandom_range(0, 1));
      rn = ($urandom_range(0, 63) != 0);
      step(v, op, q, rn);
      n_total++; if (pre_ready_dut !== exp_ready_pre) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, pre_ready_dut, exp_ready_pre); else n_pass++;
      n_total++; if (S !== exp_s) $display("FAIL rnd_S cyc=%0d got=%b exp=%b", cyc, S, exp_s); else n_pass++;
      n_total++; if (R !== exp_r) $display("FAIL rnd_R cyc=%0d got=%b exp=%b", cyc, R, exp_r); else n_pass++;
      n_total++; if ((S & R) !== 1'b0) $display("FAIL rnd_SR_excl cyc=%0d got S=%b R=%b exp never both", cyc, S, R); else n_pass++;
      n_total++; if (fifo_level !== exp_level) $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, exp_level); else n_pass++;
      n_total++; if (busy !== exp_busy) $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); else n_pass++;
`ifdef SR_CMD_STATS_EN
      n_total++; if (cmd_count !== exp_cnt) $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, cmd_count, exp_cnt); else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_back_to_back();
    test_full();
    test_nop_reset();
    test_mid_reset();
`ifdef SR_CMD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
